// File: rtl/xout_arbiter.sv
// Round-robin arbiter sharing one registered output byte (XOUT) between NREQ
// burst requesters, with a per-grant beat limit that forces release.
module xout_arbiter #(
   parameter int NREQ      = 4,
   parameter int WIDTH     = 8,
   parameter int MAX_BURST = 16
) (
   input  logic                      CLK,
   input  logic                      RESET,
   input  logic [NREQ-1:0]           REQ,
   input  logic [NREQ-1:0]           LAST,
   input  logic [NREQ*WIDTH-1:0]     DATA,
   output logic [NREQ-1:0]           GNT,
   output logic [$clog2(NREQ)-1:0]   OWNER,
   output logic [WIDTH-1:0]          XOUT,
   output logic                      XOUT_VALID,
   output logic                      BURST_CUT
);

   localparam int IW = $clog2(NREQ);
   localparam int BW = $clog2(MAX_BURST + 1);
   localparam logic [IW-1:0] TOP_IDX   = IW'(NREQ - 1);
   localparam logic [BW-1:0] BEAT_LAST = BW'(MAX_BURST - 1);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [IW-1:0]    ptr_q, ptr_d;
   logic [IW-1:0]    owner_q, owner_d;
   logic [BW-1:0]    beats_q, beats_d;
   logic [WIDTH-1:0] xout_q, xout_d;
   logic             xout_valid_q, xout_valid_d;
   logic             burst_cut_q, burst_cut_d;

   logic [WIDTH-1:0] data_arr_s [NREQ];
   logic [IW:0]      cand_s;
   logic [IW-1:0]    pick_s;
   logic [IW-1:0]    next_ptr_s;
   logic [NREQ-1:0]  gnt_s;

   // Split the flat data bus into one slice per requester
   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         data_arr_s[i] = DATA[i*WIDTH +: WIDTH];
      end
   end

   // Round-robin pick: scan from ptr downwards in priority so the nearest request wins
   always_comb begin
      pick_s = ptr_q;
      cand_s = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         cand_s = {1'b0, ptr_q} + (IW+1)'(k);
         cand_s = (cand_s >= (IW+1)'(NREQ)) ? cand_s - (IW+1)'(NREQ) : cand_s;
         pick_s = REQ[cand_s[IW-1:0]] ? cand_s[IW-1:0] : pick_s;
      end
      next_ptr_s = (owner_q == TOP_IDX) ? '0 : owner_q + IW'(1);
   end

   // Arbitration FSM next-state, grant and output-register updates
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      owner_d      = owner_q;
      beats_d      = beats_q;
      xout_d       = xout_q;
      xout_valid_d = 1'b0;
      burst_cut_d  = 1'b0;
      gnt_s        = '0;
      case (state_q)
         IDLE: begin
            if (|REQ) begin
               owner_d = pick_s;
               beats_d = '0;
               state_d = BUSY;
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            gnt_s[owner_q] = REQ[owner_q];
            if (REQ[owner_q]) begin
               xout_d       = data_arr_s[owner_q];
               xout_valid_d = 1'b1;
               beats_d      = beats_q + BW'(1);
               if (LAST[owner_q]) begin
                  state_d = IDLE;
                  ptr_d   = next_ptr_s;
               end else if (beats_q == BEAT_LAST) begin
                  burst_cut_d = 1'b1;
                  state_d     = IDLE;
                  ptr_d       = next_ptr_s;
               end else begin
                  state_d = BUSY;
               end
            end else begin
               // Owner abandoned the burst: release without writing
               state_d = IDLE;
               ptr_d   = next_ptr_s;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset wins over any transfer on the same edge
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q      <= IDLE;
         ptr_q        <= '0;
         owner_q      <= '0;
         beats_q      <= '0;
         xout_q       <= '0;
         xout_valid_q <= 1'b0;
         burst_cut_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         owner_q      <= owner_d;
         beats_q      <= beats_d;
         xout_q       <= xout_d;
         xout_valid_q <= xout_valid_d;
         burst_cut_q  <= burst_cut_d;
      end
   end

   assign GNT        = gnt_s;
   assign OWNER      = owner_q;
   assign XOUT       = xout_q;
   assign XOUT_VALID = xout_valid_q;
   assign BURST_CUT  = burst_cut_q;

endmodule
